// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan-out block: FSM states, colour field
// offsets, plane-bit selection and the gamma table used under HUB75_GAMMA_EN.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_PREFETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

  localparam int R_OFS   = 8;
  localparam int G_OFS   = 4;
  localparam int B_OFS   = 0;
  localparam int CH_W    = 4;
  localparam int PLANE_W = 2;

  // Entry i sits at bits [4*i +: 4]; the literal lists entries 15 down to 0.
  localparam logic [63:0] GAMMA_LUT = {
    4'd15, 4'd12, 4'd10, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3,
    4'd2,  4'd2,  4'd1,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [CH_W-1:0] gamma_map(input logic [CH_W-1:0] ch);
    return GAMMA_LUT[{ch, 2'b00} +: CH_W];
  endfunction

  // Returns {R,G,B} bits of one bit plane from a 12-bit pixel.
  function automatic logic [2:0] plane_rgb(input logic [11:0] pix,
                                           input logic [PLANE_W-1:0] plane);
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
    r = pix[R_OFS +: CH_W];
    g = pix[G_OFS +: CH_W];
    b = pix[B_OFS +: CH_W];
    return {r[plane], g[plane], b[plane]};
  endfunction

endpackage

// File: rtl/hub75_gamma_lut.sv
// Per-channel gamma mapping of a 12-bit {R,G,B} pixel; only built when
// HUB75_GAMMA_EN is defined, otherwise the scan path is linear.
`ifdef HUB75_GAMMA_EN
module hub75_gamma_lut
  import hub75_pkg::*;
(
  input  logic [11:0] pix_i,
  output logic [11:0] pix_o
);

  assign pix_o[R_OFS +: CH_W] = gamma_map(pix_i[R_OFS +: CH_W]);
  assign pix_o[G_OFS +: CH_W] = gamma_map(pix_i[G_OFS +: CH_W]);
  assign pix_o[B_OFS +: CH_W] = gamma_map(pix_i[B_OFS +: CH_W]);

endmodule
`endif

// File: rtl/hub75_scan.sv
// HUB75 scan-out: reads both half-frame memories and drives a 64x64 panel with
// binary-code-modulated colour. HUB75_GAMMA_EN inserts a gamma LUT on read data.
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int NUM_COLS   = 64,
  parameter int HALF_ROWS  = 32,
  parameter int BIT_DEPTH  = 4,
  parameter int BASE_DELAY = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rdata0,
  input  logic [11:0] rdata1,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        panel_clk,
  output logic        lat,
  output logic        oe_n,
  output logic [4:0]  row_sel,
  output logic        frame_done
);

  localparam int                 DLY_W      = $clog2((BASE_DELAY << (BIT_DEPTH - 1)) + 1);
  localparam logic [5:0]         COL_LAST   = 6'(NUM_COLS - 1);
  localparam logic [4:0]         ROW_LAST   = 5'(HALF_ROWS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BIT_DEPTH - 1);

  scan_state_e        state_q, state_d;
  logic [4:0]         row_q, row_d;
  logic [5:0]         col_q, col_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic               phase_q, phase_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [10:0]        rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;
  logic [5:0]         rgb_q, rgb_d;
  logic               panel_clk_q, panel_clk_d;
  logic               lat_q, lat_d;
  logic               oe_n_q, oe_n_d;
  logic [4:0]         row_sel_q, row_sel_d;
  logic               frame_done_q, frame_done_d;
  logic [11:0]        pix0, pix1;

`ifdef HUB75_GAMMA_EN
  hub75_gamma_lut u_gamma0 (.pix_i(rdata0), .pix_o(pix0));
  hub75_gamma_lut u_gamma1 (.pix_i(rdata1), .pix_o(pix1));
`else
  assign pix0 = rdata0;
  assign pix1 = rdata1;
`endif

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // so the order of these statements cannot change behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PREFETCH;
      row_q        <= '0;
      col_q        <= '0;
      plane_q      <= '0;
      phase_q      <= 1'b0;
      dly_q        <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      rgb_q        <= '0;
      panel_clk_q  <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      row_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      phase_q      <= phase_d;
      dly_q        <= dly_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      rgb_q        <= rgb_d;
      panel_clk_q  <= panel_clk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      row_sel_q    <= row_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    plane_d      = plane_q;
    phase_d      = phase_q;
    dly_d        = dly_q;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = 1'b0;
    rgb_d        = rgb_q;
    panel_clk_d  = panel_clk_q;
    lat_d        = lat_q;
    oe_n_d       = oe_n_q;
    row_sel_d    = row_sel_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_PREFETCH: begin
        rd_addr_d = {row_q, 6'd0};
        rd_en_d   = 1'b1;
        col_d     = '0;
        phase_d   = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!phase_q) begin
          rgb_d       = {plane_rgb(pix0, plane_q), plane_rgb(pix1, plane_q)};
          panel_clk_d = 1'b0;
          // Fetch the next column now; its data is held by the time it is captured.
          if (col_q != COL_LAST) begin
            rd_addr_d = {row_q, col_q + 6'd1};
            rd_en_d   = 1'b1;
          end
          phase_d = 1'b1;
        end else begin
          panel_clk_d = 1'b1;
          phase_d     = 1'b0;
          if (col_q == COL_LAST) begin
            state_d = ST_LATCH;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      ST_LATCH: begin
        if (!phase_q) begin
          panel_clk_d = 1'b0;
          lat_d       = 1'b1;
          row_sel_d   = row_q;
          phase_d     = 1'b1;
        end else begin
          lat_d   = 1'b0;
          oe_n_d  = 1'b0;
          dly_d   = DLY_W'((BASE_DELAY << plane_q) - 1);
          phase_d = 1'b0;
          state_d = ST_DISPLAY;
        end
      end
      ST_DISPLAY: begin
        if (dly_q == '0) begin
          oe_n_d  = 1'b1;
          state_d = ST_PREFETCH;
          if (plane_q == PLANE_LAST) begin
            plane_d      = '0;
            row_d        = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
            frame_done_d = (row_q == ROW_LAST);
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: state_d = ST_PREFETCH;
    endcase
  end

  assign rd_addr                    = rd_addr_q;
  assign rd_en                      = rd_en_q;
  assign {r0, g0, b0, r1, g1, b1}   = rgb_q;
  assign panel_clk                  = panel_clk_q;
  assign lat                        = lat_q;
  assign oe_n                       = oe_n_q;
  assign row_sel                    = row_sel_q;
  assign frame_done                 = frame_done_q;

endmodule
